uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one 8N1 UART transmit line among NUM_REQ byte requesters.
// The winner's byte is latched at grant, so the frame is immune to later req_data changes.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic [2:0]           active_id,
    output logic                 UART_TX
);
    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q;
    logic [CW-1:0]      baud_q;
    logic [2:0]         bit_q;
    logic [2:0]         last_q;
    logic [2:0]         active_id_q;
    logic [7:0]         shadow_q;
    logic [NUM_REQ-1:0] grant_q;
    logic               busy_q;
    logic               tx_q;

    logic [2:0]         win_d;
    logic               any_req_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [7:0]         win_data_d;
    logic               baud_end;

    assign baud_end = (baud_q == BAUD_MAX);

    // Priority distance from the last winner: the set request closest after last_q wins.
    always_comb begin : arb
        int d;
        int best;
        win_d     = '0;
        any_req_d = |req;
        best      = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = i - int'(last_q) - 1;
            if (d < 0) d = d + NUM_REQ;
            if (req[i] && d < best) begin
                best  = d;
                win_d = 3'(i);
            end
        end
    end

    always_comb begin
        grant_d    = '0;
        win_data_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_d == 3'(i)) begin
                grant_d[i] = 1'b1;
                win_data_d = req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            last_q      <= 3'(NUM_REQ - 1);
            active_id_q <= '0;
            shadow_q    <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            grant_q <= '0;
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    baud_q <= '0;
                    if (any_req_d) begin
                        grant_q     <= grant_d;
                        shadow_q    <= win_data_d;
                        active_id_q <= win_d;
                        last_q      <= win_d;
                        busy_q      <= 1'b1;
                        tx_q        <= 1'b0;
                        state_q     <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shadow_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= shadow_q[bit_q + 3'd1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                STOP: begin
                    // Returning to IDLE costs one extra high cycle before the next start bit.
                    if (baud_end) begin
                        baud_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign active_id = active_id_q;
    assign UART_TX   = tx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Directed bench for uart_tx_arbiter: a table of frames applied in a loop,
// plus hand-written sequences for data change, mid-frame reset and a withdrawn pulse.
module tb_uart_tx_arbiter;
    localparam int N     = 4;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic           clk      = 1'b0;
    logic           reset    = 1'b1;
    logic [N-1:0]   req      = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   grant;
    logic           busy;
    logic [2:0]     active_id;
    logic           UART_TX;

    int total    = 0;
    int bad      = 0;
    int idle_err = 0;

    typedef struct {
        logic [N-1:0] set_pre;
        logic [N-1:0] drop;
        logic [N-1:0] post;
        logic [N-1:0] exp_g;
        logic [7:0]   exp_byte;
    } vec_t;

    vec_t tbl [8];

    uart_tx_arbiter #(.NUM_REQ(N), .CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .grant     (grant),
        .busy      (busy),
        .active_id (active_id),
        .UART_TX   (UART_TX)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Waits for a grant, then samples one whole frame on falling edges.
    task automatic frame(input logic [N-1:0] exp_g, input logic [7:0] exp_byte,
                         input logic [N-1:0] drop, input logic [N-1:0] post,
                         input bit chg, input logic [7:0] new_d0,
                         input logic [N-1:0] pulse, input string tag);
        int         n       = 0;
        int         id      = 0;
        int         tx_err  = 0;
        int         busy_n  = 0;
        int         g_extra = 0;
        bit         seen    = 1'b0;
        logic [7:0] got     = '0;
        logic       exp_tx;
        for (int i = 0; i < N; i++) if (exp_g[i]) id = i;
        while (!seen && n < 100) begin
            @(negedge clk);
            if (grant != '0) seen = 1'b1;
            else begin
                n++;
                if (UART_TX !== 1'b1 || busy !== 1'b0) idle_err++;
            end
        end
        check({tag, ".grant"}, int'(grant), int'(exp_g));
        check({tag, ".gap"}, n, 1);
        check({tag, ".id"}, int'(active_id), id);
        req = (req & ~drop) | post;
        if (chg) req_data[7:0] = new_d0;
        for (int c = 0; c < FRAME; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 10) req = req | pulse;
            if (c == 11) req = req & ~pulse;
            if (c < CPB) exp_tx = 1'b0;
            else if (c < 9 * CPB) exp_tx = exp_byte[3'((c - CPB) / CPB)];
            else exp_tx = 1'b1;
            if (UART_TX !== exp_tx) tx_err++;
            if (busy === 1'b1) busy_n++;
            if (c > 0 && grant != '0) g_extra++;
            if (c >= CPB && c < 9 * CPB && (c % CPB) == CPB / 2)
                got[3'((c - CPB) / CPB)] = UART_TX;
        end
        check({tag, ".byte"}, int'(got), int'(exp_byte));
        check({tag, ".tx_cycles"}, tx_err, 0);
        check({tag, ".busy_len"}, busy_n, FRAME);
        check({tag, ".extra_grant"}, g_extra, 0);
    endtask

    initial begin
        int n;
        //            set_pre  drop     post     exp_g    byte
        tbl[0] = '{4'b1111, 4'b0000, 4'b0000, 4'b0001, 8'h30};
        tbl[1] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 8'h31};
        tbl[2] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 8'h32};
        tbl[3] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 8'h33};
        tbl[4] = '{4'b0000, 4'b1111, 4'b0000, 4'b0001, 8'h30};
        tbl[5] = '{4'b0100, 4'b0100, 4'b1010, 4'b0100, 8'h32};
        tbl[6] = '{4'b0000, 4'b1000, 4'b0000, 4'b1000, 8'h33};
        tbl[7] = '{4'b0000, 4'b0010, 4'b0000, 4'b0010, 8'h31};

        repeat (2) @(negedge clk);
        check("rst.tx", int'(UART_TX), 1);
        check("rst.busy", int'(busy), 0);
        check("rst.grant", int'(grant), 0);
        check("rst.id", int'(active_id), 0);

        @(posedge clk);
        #1 reset = 1'b0;
        req_data[7:0] = 8'h55;
        req = 4'b0001;
        frame(4'b0001, 8'h55, 4'b0001, '0, 1'b0, 8'h00, '0, "first");

        do_reset();
        req_data = {8'h33, 8'h32, 8'h31, 8'h30};
        for (int v = 0; v < 8; v++) begin
            req = req | tbl[v].set_pre;
            frame(tbl[v].exp_g, tbl[v].exp_byte, tbl[v].drop, tbl[v].post,
                  1'b0, 8'h00, '0, $sformatf("vec%0d", v));
        end

        req_data[7:0] = 8'hA5;
        req = 4'b0001;
        frame(4'b0001, 8'hA5, 4'b0001, '0, 1'b1, 8'h00, '0, "datachg");

        // Reset lands in data bit 3 of an all-zero byte, so the line is low beforehand.
        req_data[7:0] = 8'h00;
        req = 4'b0001;
        n = 0;
        while (grant == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midrst.grant", int'(grant), 1);
        req = '0;
        repeat (17) @(negedge clk);
        check("midrst.tx_low", int'(UART_TX), 0);
        reset = 1'b1;
        #1;
        check("midrst.tx_async", int'(UART_TX), 1);
        check("midrst.busy_async", int'(busy), 0);
        req_data[15:8] = 8'h96;
        req = 4'b0010;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        frame(4'b0010, 8'h96, 4'b0010, '0, 1'b0, 8'h00, '0, "postrst");

        req_data[31:24] = 8'hC3;
        req = 4'b1000;
        frame(4'b1000, 8'hC3, 4'b1000, '0, 1'b0, 8'h00, 4'b0100, "pulse");
        n = 0;
        repeat (3 * CPB) begin
            @(negedge clk);
            if (grant != '0 || busy !== 1'b0) n++;
        end
        check("pulse.no_grant", n, 0);
        check("idle_line", idle_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
